// File: rtl/dsp_reset_responder_if.sv
// Riser I/O bus between the host reset sequencer (master) and the DSP reset
// responder (slave).
interface dsp_reset_responder_if;
    logic [15:0] address;
    logic [15:0] data_in;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] data_out;
    logic        dsp_busy;
    logic        data_ready;

    modport master (
        output address,
        output data_in,
        output io_wr,
        output io_rd,
        input  data_out,
        input  dsp_busy,
        input  data_ready
    );

    modport slave (
        input  address,
        input  data_in,
        input  io_wr,
        input  io_rd,
        output data_out,
        output dsp_busy,
        output data_ready
    );
endinterface

// File: rtl/dsp_reset_responder.sv
// Card-side stand-in for the Sound Blaster DSP reset handshake: checks the reset
// pulse width, waits a ready delay, then presents 0x00AA with status bit 7 set.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no handshake in progress
// RST_HIGH | reset bit held high, counting pulse width (saturating)
// DELAY    | valid release seen, counting down to data ready
// READY    | 0x00AA latched, data_ready set until read-data port is read
module dsp_reset_responder #(
    parameter logic [15:0] BASE_ADDRESS       = 16'h0200,
    parameter int          RESET_HOLD_CYCLES  = 150,
    parameter int          READY_DELAY_CYCLES = 50,
    parameter int          COUNT_WIDTH        = 8
) (
    input  logic                  sys_clock,
    input  logic                  set_safe,
    dsp_reset_responder_if.slave  bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RST_HIGH = 2'd1;
    localparam logic [1:0] DELAY    = 2'd2;
    localparam logic [1:0] READY    = 2'd3;

    localparam logic [15:0] ADDR_RESET     = BASE_ADDRESS + 16'h0006;
    localparam logic [15:0] ADDR_READ_DATA = BASE_ADDRESS + 16'h000A;
    localparam logic [15:0] ADDR_WR_STATUS = BASE_ADDRESS + 16'h000C;
    localparam logic [15:0] ADDR_RD_STATUS = BASE_ADDRESS + 16'h000E;

    localparam logic [COUNT_WIDTH-1:0] HOLD_MIN   = COUNT_WIDTH'(RESET_HOLD_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] DELAY_LAST = COUNT_WIDTH'(READY_DELAY_CYCLES - 1);

    logic [1:0]             state;
    logic [COUNT_WIDTH-1:0] count;
    logic [15:0]            read_latch;
    logic [15:0]            data_out_q;
    logic                   data_ready_q;
    logic                   busy;
    logic                   wr_reset;
    logic                   rd_accept;
    logic                   rd_data_port;
    logic [15:0]            rd_value;
    logic                   unused_data_hi;

    assign busy         = (state == RST_HIGH) || (state == DELAY);
    assign wr_reset     = bus.io_wr && (bus.address == ADDR_RESET);
    // A write in the same cycle as a read always wins; the read is dropped.
    assign rd_accept    = bus.io_rd && !bus.io_wr;
    assign rd_data_port = rd_accept && (bus.address == ADDR_READ_DATA);
    assign unused_data_hi = ^bus.data_in[15:1];

    always_comb begin
        rd_value = 16'h0000;
        case (bus.address)
            ADDR_RD_STATUS: rd_value = {8'h00, data_ready_q, 7'h00};
            ADDR_WR_STATUS: rd_value = busy ? 16'h0080 : 16'h0000;
            ADDR_READ_DATA: rd_value = read_latch;
            default:        rd_value = 16'h0000;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (set_safe) begin
            state        <= IDLE;
            count        <= '0;
            read_latch   <= 16'h0000;
            data_out_q   <= 16'h0000;
            data_ready_q <= 1'b0;
        end else begin
            if (wr_reset && bus.data_in[0]) begin
                state        <= RST_HIGH;
                count        <= '0;
                data_ready_q <= 1'b0;
            end else begin
                case (state)
                    RST_HIGH: begin
                        if (wr_reset) begin
                            // Release: too-short pulses fall back to IDLE silently.
                            if (count >= HOLD_MIN) begin
                                state <= DELAY;
                                count <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (count < HOLD_MIN) begin
                            count <= count + 1'b1;
                        end
                    end
                    DELAY: begin
                        count <= count + 1'b1;
                        if (count == DELAY_LAST) begin
                            state        <= READY;
                            data_ready_q <= 1'b1;
                            read_latch   <= 16'h00AA;
                        end
                    end
                    READY: begin
                        if (rd_data_port) begin
                            state        <= IDLE;
                            data_ready_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (rd_accept) begin
                data_out_q <= rd_value;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.dsp_busy   = busy;
    assign bus.data_ready = data_ready_q;

endmodule

// File: tb/tb_dsp_reset_responder.sv
// Self-checking bench for dsp_reset_responder: scripted host sequences with a
// queue of expected read responses plus inline status-flag checks.
module tb_dsp_reset_responder;

    logic sys_clock = 1'b0;
    logic set_safe  = 1'b0;
    dsp_reset_responder_if bus ();

    dsp_reset_responder dut (
        .sys_clock (sys_clock),
        .set_safe  (set_safe),
        .bus       (bus)
    );

    always #5 sys_clock = ~sys_clock;

    int vectors     = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_data_out = 16'h0000;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clock);
            #1;
        end
    endtask

    task automatic host_write(input logic [15:0] addr, input logic [15:0] data);
        bus.address = addr;
        bus.data_in = data;
        bus.io_wr   = 1'b1;
        step(1);
        bus.io_wr   = 1'b0;
    endtask

    task automatic host_read(input string name, input logic [15:0] addr, input logic [15:0] expected);
        logic [15:0] exp_val;
        bus.address = addr;
        bus.io_rd   = 1'b1;
        exp_q.push_back(expected);
        step(1);
        bus.io_rd   = 1'b0;
        exp_val = exp_q.pop_front();
        vectors++;
        if (bus.data_out !== exp_val) begin
            miscompares++;
            $display("FAIL %s: data_out=%h expected=%h", name, bus.data_out, exp_val);
        end
        last_data_out = exp_val;
    endtask

    task automatic check_flags(input string name, input logic exp_busy, input logic exp_ready);
        vectors++;
        if (bus.dsp_busy !== exp_busy || bus.data_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL %s: busy=%b ready=%b expected busy=%b ready=%b",
                     name, bus.dsp_busy, bus.data_ready, exp_busy, exp_ready);
        end
    endtask

    // Holds reset for `hold` cycles after entry, releases, then idles in DELAY.
    task automatic valid_pulse(input int hold);
        host_write(16'h0206, 16'h0001);
        step(hold);
        host_write(16'h0206, 16'h0000);
    endtask

    task automatic watch_no_ready(input string name, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step(1);
            if (bus.data_ready === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: data_ready rose=%b expected=0", name, seen);
        end
    endtask

    task automatic test_reset();
        set_safe = 1'b1;
        step(2);
        set_safe = 1'b0;
        vectors++;
        if (bus.data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_data_out: data_out=%h expected=0000", bus.data_out);
        end
        check_flags("reset_flags", 1'b0, 1'b0);
        host_read("reset_latch", 16'h020A, 16'h0000);
    endtask

    task automatic test_nominal();
        valid_pulse(160);
        check_flags("delay_entry", 1'b1, 1'b0);
        host_read("wr_status_delay", 16'h020C, 16'h0080);
        step(47);
        host_read("rd_status_d48", 16'h020E, 16'h0000);
        // Presented in the last DELAY cycle: returns the pre-edge flag.
        host_read("rd_status_same_edge", 16'h020E, 16'h0000);
        check_flags("ready_entry", 1'b0, 1'b1);
        host_read("rd_status_ready", 16'h020E, 16'h0080);
        host_read("wr_status_ready", 16'h020C, 16'h0000);
        host_read("read_data", 16'h020A, 16'h00AA);
        check_flags("after_read", 1'b0, 1'b0);
        host_read("rd_status_idle", 16'h020E, 16'h0000);
        host_read("read_data_idle", 16'h020A, 16'h00AA);
        check_flags("idle_read_no_effect", 1'b0, 1'b0);
        host_read("undecoded", 16'h0300, 16'h0000);
        host_read("reset_port_read", 16'h0206, 16'h0000);
    endtask

    task automatic test_short_pulse();
        host_write(16'h0206, 16'h0001);
        check_flags("hold_busy", 1'b1, 1'b0);
        host_read("wr_status_hold", 16'h020C, 16'h0080);
        step(19);
        host_write(16'h0206, 16'h0000);
        check_flags("short_release", 1'b0, 1'b0);
        host_read("wr_status_short", 16'h020C, 16'h0000);
        watch_no_ready("short_no_ready", 500);
    endtask

    task automatic test_hold_boundary();
        valid_pulse(149);
        check_flags("hold_149_rejected", 1'b0, 1'b0);
        valid_pulse(150);
        check_flags("hold_150_accepted", 1'b1, 1'b0);
        step(49);
        check_flags("delay_49", 1'b1, 1'b0);
        step(1);
        check_flags("delay_50_ready", 1'b0, 1'b1);
    endtask

    task automatic test_rereset();
        host_write(16'h0206, 16'h0001);
        check_flags("rereset_drop", 1'b1, 1'b0);
        step(155);
        host_write(16'h0206, 16'h0000);
        step(50);
        check_flags("rereset_ready", 1'b0, 1'b1);
        host_read("rereset_data", 16'h020A, 16'h00AA);
    endtask

    task automatic test_ignored_writes();
        host_write(16'h020C, 16'h0001);
        check_flags("other_port_write", 1'b0, 1'b0);
        valid_pulse(160);
        step(50);
        host_write(16'h0206, 16'h0000);
        check_flags("zero_write_ready", 1'b0, 1'b1);
    endtask

    task automatic test_collision();
        host_read("pre_collision", 16'h020E, 16'h0080);
        bus.address = 16'h0206;
        bus.data_in = 16'h0001;
        bus.io_wr   = 1'b1;
        bus.io_rd   = 1'b1;
        step(1);
        bus.io_wr   = 1'b0;
        bus.io_rd   = 1'b0;
        vectors++;
        if (bus.data_out !== last_data_out) begin
            miscompares++;
            $display("FAIL collision_hold: data_out=%h expected=%h", bus.data_out, last_data_out);
        end
        check_flags("collision_flags", 1'b1, 1'b0);
    endtask

    task automatic test_set_safe_mid_delay();
        step(160);
        host_write(16'h0206, 16'h0000);
        step(20);
        check_flags("mid_delay", 1'b1, 1'b0);
        host_read("nonzero_before_abort", 16'h020C, 16'h0080);
        set_safe = 1'b1;
        step(1);
        set_safe = 1'b0;
        vectors++;
        if (bus.data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL abort_data_out: data_out=%h expected=0000", bus.data_out);
        end
        check_flags("abort_flags", 1'b0, 1'b0);
        watch_no_ready("abort_no_ready", 200);
        host_read("abort_latch", 16'h020A, 16'h0000);
    endtask

    initial begin
        bus.address = 16'h0000;
        bus.data_in = 16'h0000;
        bus.io_wr   = 1'b0;
        bus.io_rd   = 1'b0;
        step(1);
        test_reset();
        test_nominal();
        test_short_pulse();
        test_hold_boundary();
        test_rereset();
        test_ignored_writes();
        test_collision();
        test_set_safe_mid_delay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dsp_reset_responder.md
# dsp_reset_responder

Target-side model of the Sound Blaster DSP reset handshake: decodes host I/O writes to the DSP reset port and presents the matching status and data on reads. It validates the reset pulse width, waits a ready delay, then raises read-buffer status bit 7 and returns 0x00AA on the read-data port. It sits on the card side of the riser I/O bus, opposite the host reset sequencer, and lets that sequencer be exercised without a physical DSP.

## Interface
Parameters:
- BASE_ADDRESS, 16'h0200, I/O base. Ports decoded: reset at BASE+6, read data at BASE+A, write status at BASE+C, read-buffer status at BASE+E.
- RESET_HOLD_CYCLES, 150, minimum number of sys_clock cycles the reset bit must stay high (3 µs at 50 MHz).
- READY_DELAY_CYCLES, 50, cycles from a valid reset release until data is ready.
- COUNT_WIDTH, 8, counter width. Must hold max(RESET_HOLD_CYCLES, READY_DELAY_CYCLES).

Ports:
- sys_clock  in  1  system clock, rising edge.
- set_safe  in  1  synchronous, active-high reset.
- address  in  16  host I/O address, qualified by io_wr or io_rd.
- data_in  in  16  host write data; only bit 0 is used, on reset-port writes.
- io_wr  in  1  single-cycle write strobe.
- io_rd  in  1  single-cycle read strobe.
- data_out  out  16  registered read response.
- dsp_busy  out  1  high in states RST_HIGH and DELAY.
- data_ready  out  1  read-buffer-full flag; this is status bit 7.

## Operation
States: IDLE, RST_HIGH, DELAY, READY. The block keeps one counter, a read latch (16 bits) and the data_ready flag.

Write to the reset port with data_in[0]=1, from any state:
- Next state is RST_HIGH.
- Counter is cleared to 0.
- data_ready is cleared.

In RST_HIGH:
- Counter increments by 1 each cycle and saturates at RESET_HOLD_CYCLES.
- Write with data_in[0]=0 and counter ≥ RESET_HOLD_CYCLES: go to DELAY and clear the counter.
- Write with data_in[0]=0 and counter < RESET_HOLD_CYCLES: the pulse is too short. Go to IDLE; data_ready stays 0.

In DELAY:
- Counter increments each cycle.
- When counter reaches READY_DELAY_CYCLES−1: go to READY, set data_ready=1, load read latch with 16'h00AA.

In READY:
- A read of the read-data port returns the latch value, clears data_ready, and goes to IDLE.

Reset-port write with data_in[0]=0 in IDLE, DELAY or READY: ignored.

Read responses (data_out is loaded on the cycle io_rd=1):
- Read-buffer status port: {8'h00, data_ready, 7'h00}.
- Write status port: 16'h0080 while dsp_busy=1, otherwise 16'h0000.
- Read-data port: the read latch. Side effects occur only in READY. Outside READY the latch is returned unchanged and there is no state change.
- Reset port or any undecoded address: 16'h0000.
- No io_rd: data_out holds its previous value.

Writes to any address other than the reset port are ignored.

## Timing
- set_safe=1 at a clock edge gives, the next cycle: state IDLE, counter 0, read latch 16'h0000, data_out 16'h0000, data_ready 0, dsp_busy 0.
- set_safe has priority over every strobe. It aborts RST_HIGH or DELAY mid-count, and no ready event follows.
- data_out is valid on the cycle after io_rd; read latency is 1.
- Status outputs (dsp_busy, data_ready) change on the edge that changes state.
- RST_HIGH is entered on the edge after the io_wr cycle. The counter is 0 in the first RST_HIGH cycle. The hold check uses the counter value in the cycle the release write is presented.
- From the first DELAY cycle, READY and data_ready=1 arrive exactly READY_DELAY_CYCLES cycles later.
- io_wr and io_rd in the same cycle: the write is processed and the read is ignored (data_out holds).
- Read-data port read in READY on the same cycle as a reset-port write of 1: the write wins, data_out holds, and the state goes to RST_HIGH.
- A status read on the same edge that data_ready rises returns the pre-edge value (bit 7 = 0).

## Test plan
- Nominal handshake: write 1 to 0x0206, wait 160 cycles, write 0. Poll 0x020E → reads 0x0000 until 50 cycles after DELAY entry, then 0x0080. Read 0x020A → 0x00AA. Next read of 0x020E → 0x0000; state IDLE.
- Short pulse: write 1, then write 0 after 20 cycles → data_ready never rises over 500 cycles; 0x020C reads 0x0000 after the release.
- Busy status: during the hold and delay phases 0x020C reads 0x0080 and dsp_busy=1. Both return to 0x0000 and 0 in READY.
- Re-reset: while in READY, write 1 → data_ready drops on the next cycle. Complete a second valid sequence → 0x00AA is presented again.
- set_safe mid-DELAY: assert for 1 cycle → all outputs reach their reset values on the next cycle, and no ready event follows within 200 cycles.
- Collision: io_wr (0x0206, data 1) and io_rd (0x020A) in the same cycle while in READY → data_out unchanged, data_ready=0, dsp_busy=1.
